// File: rtl/fifo_rd_pkg.sv
// Shared types and default widths for the FIFO read-side controller.
// No logic; constants only.
// Imported by fifo_rd_ctrl and fifo_rd_buf.
package fifo_rd_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int STAT_W = 16;
    localparam int BUF_D  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_buf.sv
// Two-entry FIFO-ordered output buffer; the head entry drives the stream directly.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: pop is ignored when empty; the caller must never push while full without a pop.
module fifo_rd_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = fifo_rd_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data
);

    // ent0 is always the head, so head_data comes straight from a flop.
    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;

    // Shift-style storage: a pop moves ent1 into the head slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent0 <= '0;
            ent1 <= '0;
            occ  <= 2'd0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        ent0 <= push_data;
                        occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        ent0 <= push_data;
                    end else if (push) begin
                        ent1 <= push_data;
                        occ  <= 2'd2;
                    end else if (pop) begin
                        occ  <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        ent0 <= ent1;
                        if (push) begin
                            ent1 <= push_data;
                        end else begin
                            occ <= 2'd1;
                        end
                    end
                end
                default: occ <= 2'd0;
            endcase
        end
    end

    assign head_valid = (occ != 2'd0);
    assign head_data  = ent0;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Drains the 8x32 FIFO via rd_en and re-presents returned words on a valid/ready stream.
// Latency: rd_en in cycle N, capture in N+1, word on m_data from N+2.
// Backpressure: reads are only issued while buffered + in-flight words fit in the 2-entry buffer.
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = fifo_rd_pkg::DATA_W,
    parameter int CNT_W  = fifo_rd_pkg::CNT_W,
    parameter int BUF_D  = fifo_rd_pkg::BUF_D,
    parameter int STAT_W = fifo_rd_pkg::STAT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              f_empty,
    input  logic [CNT_W-1:0]  f_data_count,
    input  logic              f_rd_ack,
    input  logic              f_rd_err,
    input  logic [DATA_W-1:0] f_d_out,
    output logic              f_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic [STAT_W-1:0] words_rd,
    output logic [STAT_W-1:0] err_cnt
);

    rd_state_t   state;
    rd_state_t   state_nxt;
    logic        inflight;
    logic [1:0]  occ;
    logic        push;
    logic        pop;
    logic        err_inc;
    logic        unused_cnt;

    // Occupancy is informational; issue decisions rely on f_empty only.
    assign unused_cnt = ^f_data_count;

    // Reserve a buffer slot for every outstanding read so the buffer cannot overflow.
    assign f_rd_en = (state == RUN) && !f_empty &&
                     (({1'b0, occ} + {2'b00, inflight}) < 3'(BUF_D));

    // Responses without an outstanding read are protocol errors and are never pushed.
    assign push    = f_rd_ack && inflight;
    assign err_inc = f_rd_err || (f_rd_ack && !inflight);
    assign pop     = m_valid && m_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; re-enable in STOP wins over returning to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en) state_nxt = RUN;
            RUN:  if (!en) state_nxt = STOP;
            STOP: begin
                if (en) begin
                    state_nxt = RUN;
                end else if (!inflight) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One read may be outstanding; a new issue in the response cycle keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
        end else if (f_rd_en) begin
            inflight <= 1'b1;
        end else if (f_rd_ack || f_rd_err) begin
            inflight <= 1'b0;
        end
    end

    // Captured-word counter wraps; error counter saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words_rd <= '0;
            err_cnt  <= '0;
        end else begin
            if (push) begin
                words_rd <= words_rd + STAT_W'(1);
            end
            if (err_inc && (err_cnt != '1)) begin
                err_cnt <= err_cnt + STAT_W'(1);
            end
        end
    end

    fifo_rd_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (f_d_out),
        .pop        (pop),
        .occ        (occ),
        .head_valid (m_valid),
        .head_data  (m_data)
    );

    assign busy = (state != IDLE) || (occ != 2'd0);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: behavioural FIFO model plus a data scoreboard.
// Latency: model answers a read one cycle after rd_en, like the real FIFO.
// Backpressure: m_ready is driven per test to exercise buffer-full stalls.
module tb_fifo_rd_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic        f_empty;
    logic [3:0]  f_data_count;
    logic        f_rd_ack;
    logic        f_rd_err;
    logic [31:0] f_d_out;
    logic        f_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        busy;
    logic [15:0] words_rd;
    logic [15:0] err_cnt;

    logic [31:0] model_q[$];
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          rd_cnt = 0;
    int          err_arm = 0;
    int          err_taken = 0;
    int          inj_arm = 0;
    int          inj_taken = 0;

    fifo_rd_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .f_empty      (f_empty),
        .f_data_count (f_data_count),
        .f_rd_ack     (f_rd_ack),
        .f_rd_err     (f_rd_err),
        .f_d_out      (f_d_out),
        .f_rd_en      (f_rd_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .busy         (busy),
        .words_rd     (words_rd),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic load(input logic [31:0] w, input bit expect_it);
        model_q.push_back(w);
        if (expect_it) exp_q.push_back(w);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // FIFO model: samples rd_en mid-cycle, answers just after the next rising edge.
    initial begin
        bit req;
        f_empty = 1'b1; f_data_count = 4'd0;
        f_rd_ack = 1'b0; f_rd_err = 1'b0; f_d_out = '0;
        forever begin
            @(negedge clk);
            req = f_rd_en;
            @(posedge clk);
            #1;
            f_rd_ack = 1'b0;
            f_rd_err = 1'b0;
            if (req) begin
                if (err_arm > err_taken || model_q.size() == 0) begin
                    f_rd_err = 1'b1;
                    if (err_arm > err_taken) err_taken++;
                end else begin
                    f_rd_ack = 1'b1;
                    f_d_out  = model_q.pop_front();
                end
            end else if (inj_arm > inj_taken) begin
                inj_taken++;
                f_rd_ack = 1'b1;
                f_d_out  = 32'hDEAD_BEEF;
            end
            f_empty      = (model_q.size() == 0);
            f_data_count = 4'(model_q.size());
        end
    end

    // Monitor: read-rule check and scoreboard compare on every accepted output word.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (f_rd_en) begin
                    rd_cnt++;
                    chk("rd_en_while_empty", f_empty, 1'b0);
                end
                if (m_valid && m_ready) begin
                    chk("word_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) chk("m_data_order", m_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_base;
        int seen;
        reset = 1'b1; en = 1'b0; m_ready = 1'b0;
        cycles(3);

        // Reset state
        chk("rst_f_rd_en", f_rd_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_words_rd", words_rd, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(posedge clk); #1; reset = 1'b0;

        // 1: stream 8 words straight through
        for (int i = 0; i < 8; i++) load(32'hA0 + 32'(i), 1'b1);
        m_ready = 1'b1;
        en = 1'b1;
        wait_drain("t1_drain");
        chk("t1_words_rd", words_rd, 8);

        // 2: stalled consumer stops reads at two
        @(posedge clk); #1;
        m_ready = 1'b0;
        rd_base = rd_cnt;
        for (int i = 0; i < 5; i++) load(32'hB0 + 32'(i), 1'b1);
        cycles(12);
        chk("t2_reads_stalled", rd_cnt - rd_base, 2);
        chk("t2_model_left", model_q.size(), 3);
        chk("t2_f_rd_en", f_rd_en, 0);
        chk("t2_m_valid", m_valid, 1);
        chk("t2_head", m_data, 32'hB0);
        chk("t2_busy", busy, 1);
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_drain("t2_drain");
        chk("t2_reads_total", rd_cnt - rd_base, 5);
        chk("t2_words_rd", words_rd, 13);

        // 3: one read rejected, then normal operation
        rd_base = rd_cnt;
        err_arm++;
        load(32'hC0, 1'b1);
        load(32'hC1, 1'b1);
        wait_drain("t3_drain");
        chk("t3_err_cnt", err_cnt, 1);
        chk("t3_words_rd", words_rd, 15);
        chk("t3_reads", rd_cnt - rd_base, 3);

        // 4: en dropped in the same cycle as a read
        @(posedge clk); #1;
        m_ready = 1'b0;
        rd_base = rd_cnt;
        load(32'hD0, 1'b1);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (f_rd_en) seen = 1;
        end
        chk("t4_read_seen", seen, 1);
        en = 1'b0;
        cycles(3);
        chk("t4_busy_held", busy, 1);
        chk("t4_m_valid", m_valid, 1);
        chk("t4_head", m_data, 32'hD0);
        chk("t4_words_rd", words_rd, 16);
        load(32'hD1, 1'b1);
        cycles(5);
        chk("t4_no_new_reads", rd_cnt - rd_base, 1);
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 1; i++) @(negedge clk);
        @(negedge clk);
        chk("t4_idle_busy", busy, 0);
        en = 1'b1;
        wait_drain("t4_drain");
        chk("t4_words_rd_end", words_rd, 17);

        // 5: reset with a buffered word and a read in flight
        @(posedge clk); #1;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(32'hE0 + 32'(i), 1'b0);
        seen = 0;
        for (int i = 0; i < 30 && seen < 2; i++) begin
            @(negedge clk);
            if (f_rd_en) seen++;
        end
        chk("t5_two_reads", seen, 2);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("t5_f_rd_en", f_rd_en, 0);
        chk("t5_m_valid", m_valid, 0);
        chk("t5_m_data", m_data, 0);
        chk("t5_busy", busy, 0);
        chk("t5_words_rd", words_rd, 0);
        chk("t5_err_cnt", err_cnt, 0);
        model_q.delete();
        cycles(2);
        @(posedge clk); #1;
        reset = 1'b0;
        m_ready = 1'b1;
        cycles(10);
        chk("t5_after_m_valid", m_valid, 0);
        chk("t5_after_words_rd", words_rd, 0);
        chk("t5_after_busy", busy, 1);

        // 6: unsolicited ack is an error, not a word
        en = 1'b0;
        cycles(4);
        inj_arm++;
        cycles(4);
        chk("t6_err_cnt", err_cnt, 1);
        chk("t6_m_valid", m_valid, 0);
        chk("t6_words_rd", words_rd, 0);
        chk("t6_busy", busy, 0);
        chk("t6_inject_used", inj_taken, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
